// File: rtl/id_ex_stage.sv
// id_ex_stage: ID->EX pipeline register with immediate formation, destination select and load-use hazard detection
// Inputs: decode control bits, register indices, immediate, operand data and PC+4; flush redirects from EX.
// Outputs: registered EX copy of all of the above, combinational stall for IF/ID, saturating bubble counter.
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_regwrite,
    input  logic              id_regread,
    input  logic              id_memread,
    input  logic              id_memwrite,
    input  logic              id_branch,
    input  logic              id_toreg,
    input  logic              id_rt_rd,
    input  logic [5:0]        id_opcode,
    input  logic [5:0]        id_funct,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic [4:0]        id_rd,
    input  logic [15:0]       id_imm,
    input  logic [DATA_W-1:0] id_rdata1,
    input  logic [DATA_W-1:0] id_rdata2,
    input  logic [DATA_W-1:0] id_pc4,
    input  logic              flush,
    output logic              stall,
    output logic              ex_valid,
    output logic              ex_regwrite,
    output logic              ex_memread,
    output logic              ex_memwrite,
    output logic              ex_branch,
    output logic              ex_toreg,
    output logic [5:0]        ex_opcode,
    output logic [5:0]        ex_funct,
    output logic [4:0]        ex_rs,
    output logic [4:0]        ex_rt,
    output logic [4:0]        ex_dest,
    output logic [DATA_W-1:0] ex_rdata1,
    output logic [DATA_W-1:0] ex_rdata2,
    output logic [DATA_W-1:0] ex_imm,
    output logic [DATA_W-1:0] ex_pc4,
    output logic [CNT_W-1:0]  stall_count
);
    logic              rs_hit, rt_hit, hz;
    logic [DATA_W-1:0] imm_x;
    logic [4:0]        dest;
    always_comb begin
        rs_hit = id_regread & (ex_dest == id_rs);
        // rt is a source for stores and for rd-format instructions that read registers
        rt_hit = (ex_dest == id_rt) & (id_memwrite | (id_regread & ~id_rt_rd));
        hz     = ex_valid & ex_memread & (ex_dest != 5'd0) & (rs_hit | rt_hit);
        stall  = hz & ~flush;
        imm_x  = (id_opcode == 6'b001100 || id_opcode == 6'b001101) ? DATA_W'(id_imm) :
                 (id_opcode == 6'b001111) ? DATA_W'({id_imm, 16'h0}) :
                 DATA_W'(signed'(id_imm));
        dest   = (id_opcode == 6'b000011) ? 5'd31 : id_rt_rd ? id_rt : id_rd;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid    <= 1'b0;
            ex_regwrite <= 1'b0;
            ex_memread  <= 1'b0;
            ex_memwrite <= 1'b0;
            ex_branch   <= 1'b0;
            ex_toreg    <= 1'b0;
            ex_opcode   <= '0;
            ex_funct    <= '0;
            ex_rs       <= '0;
            ex_rt       <= '0;
            ex_dest     <= '0;
            ex_rdata1   <= '0;
            ex_rdata2   <= '0;
            ex_imm      <= '0;
            ex_pc4      <= '0;
            stall_count <= '0;
        end else if (flush | hz) begin
            // bubble: kill side-effecting controls, data fields keep stale values
            ex_valid    <= 1'b0;
            ex_regwrite <= 1'b0;
            ex_memread  <= 1'b0;
            ex_memwrite <= 1'b0;
            ex_branch   <= 1'b0;
            if (stall && stall_count != '1)
                stall_count <= stall_count + 1'b1;
        end else begin
            ex_valid    <= 1'b1;
            ex_regwrite <= id_regwrite;
            ex_memread  <= id_memread;
            ex_memwrite <= id_memwrite;
            ex_branch   <= id_branch;
            ex_toreg    <= id_toreg;
            ex_opcode   <= id_opcode;
            ex_funct    <= id_funct;
            ex_rs       <= id_rs;
            ex_rt       <= id_rt;
            ex_dest     <= dest;
            ex_rdata1   <= id_rdata1;
            ex_rdata2   <= id_rdata2;
            ex_imm      <= imm_x;
            ex_pc4      <= id_pc4;
        end
    end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
ID→EX pipeline register for the MIPS_32 core. It sits directly downstream of the decode control unit.
- Latches that unit's control bits, the register-file operands and the immediate into the EX stage.
- Forms the immediate per opcode and resolves the destination register.
- Detects load-use hazards: raises a stall for IF/ID and injects a bubble into EX.
- Honours a branch/jump flush from EX.

Parameters:
DATA_W, 32, operand/immediate/pc width
CNT_W, 8, width of saturating stall counter

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high
id_regwrite  in  1  control unit RegWrite
id_regread  in  1  control unit RegRead
id_memread  in  1  control unit MemRead
id_memwrite  in  1  control unit MemWrite
id_branch  in  1  control unit Branch
id_toreg  in  1  control unit toReg (0 ALU, 1 mem)
id_rt_rd  in  1  control unit rt_rd (0 rd, 1 rt)
id_opcode  in  6  instr[31:26]
id_funct  in  6  instr[5:0]
id_rs, id_rt, id_rd  in  5 each  register indices
id_imm  in  16  instr[15:0]
id_rdata1, id_rdata2  in  DATA_W  register-file read data
id_pc4  in  DATA_W  PC+4 of decode instruction
flush  in  1  EX redirect (taken branch/jump)
stall  out  1  hold PC and IF/ID this cycle (combinational)
ex_valid  out  1  EX holds a real instruction
ex_regwrite, ex_memread, ex_memwrite, ex_branch, ex_toreg  out  1 each  registered control
ex_opcode, ex_funct  out  6 each  registered for ALU control
ex_rs, ex_rt  out  5 each  registered for forwarding
ex_dest  out  5  resolved write register
ex_rdata1, ex_rdata2, ex_imm, ex_pc4  out  DATA_W each  registered operands
stall_count  out  CNT_W  saturating count of injected load-use bubbles

Behaviour:
- Reset (reset=1 at edge): every ex_* output = 0, stall_count = 0. stall stays a combinational function of current state; it is 0 after reset because ex_memread=0.
- Reset mid-stream discards the EX contents; no partial update.
- Latency: one cycle, ID inputs to ex_* outputs.
- Immediate formation, registered into ex_imm:
  - opcode 001100 (andi) or 001101 (ori): zero-extend.
  - opcode 001111 (lui): {imm,16'h0}.
  - All other opcodes: sign-extend imm[15] to DATA_W.
- Destination: ex_dest = id_rt_rd ? id_rt : id_rd. Opcode 000011 (jal) forces dest = 31.
- Hazard term: hz = ex_valid & ex_memread & (ex_dest≠0) & (rs_hit | rt_hit).
  - rs_hit = id_regread & (ex_dest==id_rs).
  - rt_hit = (ex_dest==id_rt) & (id_memwrite | (id_regread & ~id_rt_rd)).
- stall = hz & ~flush.
- Next-state priority, highest first:
  1. reset → all zero.
  2. flush → bubble.
  3. hz → bubble, and stall_count += 1, saturating at 2^CNT_W−1 (no wrap).
  4. else → load ID inputs, ex_valid = 1.
- Bubble definition:
  - ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_branch = 0.
  - Data/index fields hold their prior value (don't-care).
- Flush together with hz: bubble inserted, stall=0, stall_count unchanged.
- One bubble resolves a load-use hazard. On the next cycle EX holds the bubble (memread=0), so stall drops; no back-to-back stall from the same load.
- ex_dest=0 never produces a stall.

Test Plan:
- Reset: assert reset 2 cycles with nonzero inputs → all ex_* = 0, stall_count = 0, stall = 0.
- Pass-through: addi (opcode 001000, rt=5, imm=16'hFFFC, rdata1=10) → next cycle ex_valid=1, ex_regwrite=1, ex_dest=5, ex_imm=32'hFFFFFFFC.
- Immediate forms:
  - ori imm=16'h8001 → ex_imm=32'h00008001.
  - lui imm=16'h1234 → ex_imm=32'h12340000.
- Load-use: lw with rt=8 in EX, then R-type add with rs=8 in ID → stall=1 one cycle, EX bubble (ex_regwrite=0), stall_count=1; the add enters EX on the following cycle with stall=0.
- No false hazard:
  - lw to r0 followed by an instruction reading r0 → stall=0.
  - lw r8 followed by lui r8 (regread=0) → stall=0.
- Flush priority: hazard condition present and flush=1 → stall=0, bubble in EX, stall_count unchanged. Then drive 300 load-use hazards → stall_count saturates at 255.
